// File: rtl/im_uart_loader_pkg.sv
// Shared types for the UART program loader: receiver state encoding and baud helper.
package im_uart_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/im_uart_loader_if.sv
// Loader-side bundle: host serial/enable inputs and the instruction-memory write port.
interface im_uart_loader_if #(parameter int ADDR_W = 6);
  logic              load_en;
  logic              rx;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [ADDR_W:0]   words_loaded;
  logic              load_done;
  logic              frame_err;
  logic              busy;

  modport master (output load_en, rx,
                  input  im_we, im_addr, im_wdata, words_loaded, load_done, frame_err, busy);
  modport slave  (input  load_en, rx,
                  output im_we, im_addr, im_wdata, words_loaded, load_done, frame_err, busy);
endinterface

// File: rtl/im_uart_loader_rx.sv
// UART 8N1 byte receiver: rx synchroniser, mid-bit sampling FSM, one-cycle result pulses.
module uart_rx_byte
  import im_uart_loader_pkg::*;
#(
  parameter int CPB = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_pulse,
  output logic       busy
);
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CPB - 1);

  logic             rx_s1, rx_s2;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  assign byte_data = shreg;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
    end else begin
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
      if (!en) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        bit_idx <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt     <= '0;
            bit_idx <= '0;
            if (!rx_s2) state <= ST_START;
          end
          // half-bit wait lands later samples near bit centres; a high here was a glitch
          ST_START: begin
            if (cnt == HALF) begin
              cnt   <= '0;
              state <= rx_s2 ? ST_IDLE : ST_DATA;
            end else cnt <= cnt + 1'b1;
          end
          ST_DATA: begin
            if (cnt == FULL) begin
              cnt     <= '0;
              shreg   <= {rx_s2, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) state <= ST_STOP;
            end else cnt <= cnt + 1'b1;
          end
          ST_STOP: begin
            if (cnt == FULL) begin
              cnt             <= '0;
              byte_valid      <= rx_s2;
              frame_err_pulse <= ~rx_s2;
              state           <= ST_IDLE;
            end else cnt <= cnt + 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: rtl/im_uart_loader.sv
// Packs received bytes little-endian into words and streams them into instruction memory.
module im_uart_loader
  import im_uart_loader_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 6
) (
  input logic             clk,
  input logic             rst,
  im_uart_loader_if.slave bus
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic       byte_valid, ferr_pulse, rx_busy, load_en_q;
  logic [7:0] byte_data;
  logic [1:0] byte_idx;
  logic [23:0] word_buf;

  uart_rx_byte #(.CPB(CLKS_PER_BIT)) u_rx (
    .clk             (clk),
    .rst             (rst),
    .en              (bus.load_en),
    .rx              (bus.rx),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .frame_err_pulse (ferr_pulse),
    .busy            (rx_busy)
  );

  assign bus.busy = rx_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_en_q        <= 1'b0;
      byte_idx         <= '0;
      word_buf         <= '0;
      bus.im_we        <= 1'b0;
      bus.im_addr      <= '0;
      bus.im_wdata     <= '0;
      bus.words_loaded <= '0;
      bus.load_done    <= 1'b0;
      bus.frame_err    <= 1'b0;
    end else begin
      load_en_q <= bus.load_en;
      bus.im_we <= 1'b0;
      if (!bus.load_en) begin
        byte_idx         <= '0;
        bus.im_addr      <= '0;
        bus.words_loaded <= '0;
      end else begin
        if (!load_en_q) begin
          bus.load_done <= 1'b0;
          bus.frame_err <= 1'b0;
        end
        if (ferr_pulse) bus.frame_err <= 1'b1;
        // address advances the cycle after the strobe so addr/data stay stable during it
        if (bus.im_we) begin
          bus.im_addr <= bus.im_addr + 1'b1;
          if (&bus.im_addr) bus.load_done <= 1'b1;
          if (bus.words_loaded != WORDS_MAX) bus.words_loaded <= bus.words_loaded + 1'b1;
        end
        if (byte_valid) begin
          case (byte_idx)
            2'd0: word_buf[7:0]   <= byte_data;
            2'd1: word_buf[15:8]  <= byte_data;
            2'd2: word_buf[23:16] <= byte_data;
            default: begin
              bus.im_we    <= 1'b1;
              bus.im_wdata <= {byte_data, word_buf};
            end
          endcase
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_im_uart_loader.sv
// Bench for im_uart_loader: table vectors, random words vs a queue-based model, corner sequences.
module tb_im_uart_loader;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  im_uart_loader_if #(.ADDR_W(6)) bus();

  im_uart_loader #(.CLK_FREQ(16), .BAUD(1), .ADDR_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed { logic [5:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [3:0][7:0] b; logic [31:0] word; } vec_t;

  wr_t        exp_q[$];
  logic [7:0] mbytes[$];
  int         m_addr = 0, m_words = 0;
  bit         m_done = 0, m_ferr = 0, m_en = 0;
  int         total = 0, bad = 0;
  logic       prev_we = 1'b0;
  vec_t       tbl[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // every write strobe must match the next expected write, and last exactly one cycle
  always @(negedge clk) begin
    wr_t w;
    if (bus.im_we === 1'b1) begin
      check("we_one_cycle", {31'b0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=%0h none expected", bus.im_addr, bus.im_wdata);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", {26'b0, bus.im_addr}, {26'b0, w.addr});
        check("wr_data", bus.im_wdata, w.data);
      end
    end
    prev_we = bus.im_we;
  end

  task automatic expect_write(input logic [31:0] word);
    exp_q.push_back('{addr: 6'(m_addr), data: word});
    if (m_addr == 63) m_done = 1;
    m_addr  = (m_addr + 1) % 64;
    m_words = (m_words < 64) ? m_words + 1 : 64;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [31:0] w;
    mbytes.push_back(b);
    if (mbytes.size() == 4) begin
      w = 32'(mbytes[0]) + (32'(mbytes[1]) << 8) + (32'(mbytes[2]) << 16) + (32'(mbytes[3]) << 24);
      expect_write(w);
      mbytes.delete();
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (CPB) @(negedge clk);
      if (i == 3) check("busy_mid_frame", {31'b0, bus.busy}, 32'd1);
    end
    bus.rx = stop;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) model_byte(b);
    else m_ferr = 1;
    send_bits(b, stop_ok);
    if (!stop_ok) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_rand_word();
    for (int j = 0; j < 4; j++) send_byte(8'($urandom), 1'b1);
  endtask

  task automatic set_load_en(input bit v);
    if (!v) begin
      mbytes.delete();
      m_addr  = 0;
      m_words = 0;
    end else if (!m_en) begin
      m_done = 0;
      m_ferr = 0;
    end
    m_en = v;
    bus.load_en = v;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_model();
    check("words_loaded", {25'b0, bus.words_loaded}, 32'(m_words));
    check("im_addr", {26'b0, bus.im_addr}, 32'(m_addr));
    check("load_done", {31'b0, bus.load_done}, {31'b0, m_done});
    check("frame_err", {31'b0, bus.frame_err}, {31'b0, m_ferr});
  endtask

  task automatic drain_and_check();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check_model();
  endtask

  initial begin
    bus.load_en = 1'b0;
    bus.rx      = 1'b1;
    tbl[0] = '{b: {8'h00, 8'h10, 8'h05, 8'h13}, word: 32'h00100513};
    tbl[1] = '{b: {8'h00, 8'h20, 8'h05, 8'h93}, word: 32'h00200593};
    tbl[2] = '{b: {8'hDE, 8'hAD, 8'hBE, 8'hEF}, word: 32'hDEADBEEF};
    tbl[3] = '{b: {8'h00, 8'h00, 8'h00, 8'h00}, word: 32'h00000000};
    tbl[4] = '{b: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, word: 32'hFFFFFFFF};

    repeat (3) @(negedge clk);
    check("rst_im_we", {31'b0, bus.im_we}, 32'd0);
    check("rst_im_addr", {26'b0, bus.im_addr}, 32'd0);
    check("rst_im_wdata", bus.im_wdata, 32'd0);
    check("rst_words", {25'b0, bus.words_loaded}, 32'd0);
    check("rst_done", {31'b0, bus.load_done}, 32'd0);
    check("rst_ferr", {31'b0, bus.frame_err}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    set_load_en(1);

    // first word alone, then the rest of the table back-to-back
    for (int i = 0; i < 5; i++) begin
      expect_write(tbl[i].word);
      for (int j = 0; j < 4; j++) send_bits(tbl[i].b[j], 1'b1);
      if (i == 0) drain_and_check();
    end
    drain_and_check();

    // 4-clock low pulse on rx: start rejected, nothing received
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_start", {31'b0, bus.busy}, 32'd1);
    repeat (30) @(negedge clk);
    check("glitch_busy_idle", {31'b0, bus.busy}, 32'd0);
    check("glitch_ferr", {31'b0, bus.frame_err}, 32'd0);
    send_rand_word();
    drain_and_check();

    // bad stop bit: byte dropped, sticky error, next word from good bytes only
    send_byte(8'hAA, 1'b0);
    check("ferr_set", {31'b0, bus.frame_err}, 32'd1);
    send_rand_word();
    drain_and_check();

    for (int k = 0; k < 6; k++) send_rand_word();
    drain_and_check();

    // fill all 64 words, then one more to see the wrap
    set_load_en(0);
    set_load_en(1);
    check_model();
    for (int k = 0; k < 63; k++) send_rand_word();
    drain_and_check();
    send_rand_word();
    drain_and_check();
    send_rand_word();
    drain_and_check();

    // load_en dropped mid-word: partial discarded, sticky flags held until next rise
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    set_load_en(0);
    repeat (5) @(negedge clk);
    check_model();
    set_load_en(1);
    check_model();
    send_rand_word();
    drain_and_check();

    // reset in the middle of the 4th byte's data bits
    for (int j = 0; j < 3; j++) send_byte(8'($urandom), 1'b1);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.rx = 1'(i & 1);
      repeat (CPB) @(negedge clk);
    end
    check("busy_before_rst", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mrst_im_we", {31'b0, bus.im_we}, 32'd0);
    check("mrst_im_addr", {26'b0, bus.im_addr}, 32'd0);
    check("mrst_im_wdata", bus.im_wdata, 32'd0);
    check("mrst_words", {25'b0, bus.words_loaded}, 32'd0);
    check("mrst_done", {31'b0, bus.load_done}, 32'd0);
    check("mrst_busy", {31'b0, bus.busy}, 32'd0);
    mbytes.delete();
    exp_q.delete();
    m_addr = 0; m_words = 0; m_done = 0; m_ferr = 0;
    bus.rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    send_rand_word();
    drain_and_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
